prog_load_ctrl: RTL

- Sequencer that fills instruction memory from a UART byte stream before the core enters EXEC.
- Assembles received bytes into 32-bit words and writes them through the instruction-memory write port at consecutive word addresses.
- Detects the program terminator word, reports completion and word count, and returns a one-byte acknowledge to the host through the UART transmitter handshake.
- Sits between uart_rx/uart_tx and the instruction-memory write port. The core's fetch only reads memory while this block reports done.

---
 rtl/prog_load_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/prog_load_ctrl.sv
// Boot loader sequencer: packs UART bytes big-endian into 32-bit words, writes them to
// instruction memory at consecutive addresses, and acknowledges the host when loading ends.
`timescale 1ns/1ps
module prog_load_ctrl #(
    parameter int unsigned INST_SIZE = 14,
    parameter logic [31:0] END_WORD  = 32'h0000003F,
    parameter logic [7:0]  ACK_OK    = 8'hAA,
    parameter logic [7:0]  ACK_OVF   = 8'hEE
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 tx_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 we,
    output logic [INST_SIZE-1:0] waddr,
    output logic [31:0]          wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [INST_SIZE:0]   word_count
);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, ACK, DONE} state_t;

    state_t                 state, state_nxt;
    logic [1:0]             rst_sync;
    logic                   rst_int_n;
    logic [INST_SIZE-1:0]   addr;
    logic [1:0]             byte_cnt;
    logic [31:0]            shreg;
    logic [7:0]             ack_byte;
    logic                   shift_en;
    logic                   clear;
    logic                   is_end;
    logic                   at_top;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync <= '0;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign is_end = (shreg == END_WORD);
    assign at_top = &addr;

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RECV;
                    clear     = 1'b1;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    shift_en = 1'b1;
                    if (byte_cnt == 2'd3) state_nxt = WRITE;
                end
            end
            WRITE: begin
                // The shift register still holds the word here; a byte arriving now starts the next word.
                if (is_end || at_top) begin
                    state_nxt = ACK;
                end else begin
                    state_nxt = RECV;
                    shift_en  = rx_valid;
                end
            end
            ACK: begin
                if (tx_ready) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            addr       <= '0;
            byte_cnt   <= '0;
            shreg      <= '0;
            ack_byte   <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                addr       <= '0;
                byte_cnt   <= '0;
                shreg      <= '0;
                overflow   <= 1'b0;
                word_count <= '0;
            end
            if (shift_en) begin
                shreg    <= {shreg[23:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == WRITE) begin
                word_count <= word_count + (INST_SIZE+1)'(1);
                if (is_end) begin
                    ack_byte <= ACK_OK;
                end else if (at_top) begin
                    overflow <= 1'b1;
                    ack_byte <= ACK_OVF;
                end else begin
                    addr <= addr + INST_SIZE'(1);
                end
            end
        end
    end

    assign we       = (state == WRITE);
    assign waddr    = addr;
    assign wdata    = shreg;
    assign tx_valid = (state == ACK);
    assign tx_data  = ack_byte;
    assign busy     = (state == RECV) || (state == WRITE) || (state == ACK);
    assign done     = (state == DONE);

endmodule
